prio_chain_arbiter: RTL and testbench
=====================================

# prio_chain_arbiter

Fixed-priority arbiter that shares one downstream resource among NREQ requesters, giving the same winner an if / else-if priority chain would pick. Index 0 has the highest priority. It adds three things a plain chain lacks:
- grant locking while the holder keeps requesting,
- a hold limit so low-priority requesters cannot be starved,
- an optional unique0 checker that flags simultaneous requests.

It sits between request sources and the shared resource's select mux.

## Interface
Parameters:
- NREQ, 12, number of requesters; legal range 2..32.
- MAX_HOLD, 8, maximum consecutive cycles one holder keeps the grant while other requests are pending; legal range ≥1.
- IDXW, $clog2(NREQ), width of grant_idx.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request vector; bit i high means requester i wants the resource.
- unique_en  in  1  enables the unique0 overlap check.
- grant  out  NREQ  one-hot grant, or all zero; registered.
- grant_valid  out  1  equals |grant; registered.
- grant_idx  out  IDXW  index of the granted requester; 0 when grant_valid=0.
- overlap  out  1  one-cycle pulse reporting a unique0 violation.
- overlap_cnt  out  8  saturating count of overlap events.

## Operation
- Reset: the state goes to IDLE. grant, grant_valid, grant_idx, overlap, overlap_cnt and hold_cnt all clear to 0.
- States are IDLE (no holder) and BUSY (holder h, with hold_cnt counting cycles held).
- IDLE:
  - With req==0, stay in IDLE.
  - Otherwise grant the lowest set index w of req, go to BUSY, set hold_cnt=1.
- BUSY, one decision per edge, in this order:
  1. req[h]==0: release. Re-arbitrate the same edge over req with bit h masked. If any bit is set, grant it and set hold_cnt=1 (back-to-back, no gap); else go to IDLE.
  2. req[h]==1 and hold_cnt==MAX_HOLD and (req with h masked)!=0: force release. Grant the lowest set index of the masked vector and set hold_cnt=1.
  3. req[h]==1 and hold_cnt==MAX_HOLD and no other request: h keeps the grant and hold_cnt restarts at 1.
  4. Otherwise h keeps the grant and hold_cnt increments.
- Priority is strict lowest-index-wins at every arbitration. There is no round-robin; the fairness guarantee is only the MAX_HOLD bound.
- While BUSY, a higher-priority request does not preempt the holder. It waits for release or for the hold limit.
- Overlap check:
  - Evaluated only on edges where a new arbitration occurs: leaving IDLE, rule 1 with a winner found, or rule 2.
  - If unique_en=1 and the arbitrated vector has popcount ≥2, then overlap=1 for exactly the next cycle and overlap_cnt increments, saturating at 255.
  - The arbitrated vector is req, or req with h masked for rules 1 and 2.
  - The grant is still issued normally; the check never blocks arbitration.
- A holder dropping req and re-raising it on the next cycle is treated as a new request at its normal priority.
- Widths: hold_cnt is $clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD. grant_idx is the binary encode of grant.

## Timing
- Latency from req to grant is 1 cycle: req is sampled at edge t and grant is visible after edge t.
- Release to next grant is 0 idle cycles. grant changes holder on the same edge that samples req[h]=0.
- For a continuously contested resource, the holder owns the grant for exactly MAX_HOLD cycles, then the grant moves.
- overlap is asserted in the same cycle as the grant it describes.
- rst asserted mid-BUSY: the next edge clears all outputs regardless of req. Arbitration resumes on the first edge with rst=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and single request:
  - Stimulus: rst for 2 cycles, then req=12'h010.
  - Required: grant=12'h010, grant_idx=4 one cycle later. Drop req and grant goes to 0 the next cycle.
- Priority and no preemption:
  - Stimulus: req=12'h800 granted (idx 11), then req=12'h801.
  - Required: grant stays on 11 until req[11] drops; then idx 0 is granted on the same edge.
- Hold limit, MAX_HOLD=8:
  - Stimulus: hold req=12'h003 constant.
  - Required: grant alternates 0,1,0,… every 8 cycles. With only req[0] set, grant stays on 0 indefinitely.
- Unique0 check:
  - Stimulus: unique_en=1 with req=12'h041 from IDLE.
  - Required: grant idx 0, overlap pulses 1 cycle, overlap_cnt=1.
  - Repeat with unique_en=0: overlap stays 0.
- Overlap saturation:
  - Stimulus: 300 overlapping arbitrations.
  - Required: overlap_cnt=255.
- Mid-operation reset:
  - Stimulus: assert rst while BUSY at hold_cnt=5.
  - Required: all outputs are 0 next cycle. After rst falls, a fresh grant occurs with the full MAX_HOLD budget.

Source files
------------

// File: rtl/prio_chain_arbiter.sv
// Fixed-priority arbiter (index 0 highest) with grant locking, a hold limit that
// bounds starvation, and an optional overlap checker on arbitrated request vectors.
module prio_chain_arbiter #(
  parameter int unsigned NREQ     = 12,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDXW     = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            unique_en,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic            overlap,
  output logic [7:0]      overlap_cnt
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              overlap_q, overlap_d;
  logic [7:0]        ocnt_q, ocnt_d;

  logic [NREQ-1:0]   arb_vec;
  logic [NREQ-1:0]   win_onehot;
  logic [IDXW-1:0]   win_idx;
  logic              win_found;
  logic              holder_req;
  logic              hold_limit;
  logic              multi_req;
  logic              arb;

  // grant_q is zero in IDLE, so masking by it yields req there and req-minus-holder in BUSY.
  assign arb_vec    = req & ~grant_q;
  assign holder_req = |(req & grant_q);
  assign hold_limit = (hold_q == HoldW'(MAX_HOLD));
  assign win_onehot = arb_vec & (~arb_vec + NREQ'(1));
  assign multi_req  = |(arb_vec & (arb_vec - NREQ'(1)));

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_vec[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    arb     = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) arb = 1'b1;
      end
      StBusy: begin
        if (!holder_req) begin
          if (win_found) begin
            arb = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_limit) begin
          if (win_found) arb = 1'b1;
          else           hold_d = HoldW'(1);
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase

    if (arb) begin
      state_d = StBusy;
      grant_d = win_onehot;
      idx_d   = win_idx;
      hold_d  = HoldW'(1);
    end

    valid_d   = |grant_d;
    overlap_d = arb & unique_en & multi_req;
    ocnt_d    = (overlap_d && ocnt_q != 8'hff) ? ocnt_q + 8'd1 : ocnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      hold_q    <= '0;
      overlap_q <= 1'b0;
      ocnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      overlap_q <= overlap_d;
      ocnt_q    <= ocnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign overlap     = overlap_q;
  assign overlap_cnt = ocnt_q;

endmodule

// File: tb/tb_prio_chain_arbiter.sv
// Bench for prio_chain_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a holder/counter model of the arbitration rules.
module tb_prio_chain_arbiter;

  localparam int unsigned NREQ     = 12;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned IDXW     = $clog2(NREQ);

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic            unique_en;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic            overlap;
  logic [7:0]      overlap_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: holder index (-1 means none), cycles held, overlap pulse and count.
  int m_holder = -1;
  int m_hold   = 0;
  int m_ocnt   = 0;
  bit m_ovl    = 1'b0;

  prio_chain_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .unique_en   (unique_en),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .overlap     (overlap),
    .overlap_cnt (overlap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NREQ-1:0] v);
    for (int i = 0; i < int'(NREQ); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [NREQ-1:0] r, input logic ue, input logic rs);
    logic [NREQ-1:0] vec;
    bit              do_arb;
    do_arb = 1'b0;
    vec    = r;
    m_ovl  = 1'b0;
    if (rs) begin
      m_holder = -1;
      m_hold   = 0;
      m_ocnt   = 0;
      return;
    end
    if (m_holder < 0) begin
      do_arb = (r != 0);
    end else begin
      vec[m_holder] = 1'b0;
      if (!r[m_holder]) begin
        if (vec != 0) do_arb = 1'b1;
        else begin
          m_holder = -1;
          m_hold   = 0;
        end
      end else if (m_hold == int'(MAX_HOLD)) begin
        if (vec != 0) do_arb = 1'b1;
        else          m_hold = 1;
      end else begin
        m_hold++;
      end
    end
    if (do_arb) begin
      m_holder = lowest(vec);
      m_hold   = 1;
      if (ue && $countones(vec) >= 2) begin
        m_ovl = 1'b1;
        if (m_ocnt < 255) m_ocnt++;
      end
    end
  endtask

  // Apply inputs just after an edge, clock once, then compare all outputs to the model.
  task automatic cycle(input logic [NREQ-1:0] r, input logic ue, input logic rs);
    logic [NREQ-1:0] eg;
    rst       = rs;
    req       = r;
    unique_en = ue;
    @(posedge clk);
    #1;
    model_step(r, ue, rs);
    eg = (m_holder >= 0) ? (NREQ'(1) << m_holder) : '0;
    check("grant", 32'(grant), 32'(eg));
    check("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
    check("grant_idx", 32'(grant_idx), (m_holder >= 0) ? 32'(m_holder) : 32'd0);
    check("overlap", 32'(overlap), 32'(m_ovl));
    check("overlap_cnt", 32'(overlap_cnt), 32'(m_ocnt));
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] exp_g;

    // Reset and single request
    cycle(12'h000, 1'b0, 1'b1);
    cycle(12'h000, 1'b0, 1'b1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cnt", 32'(overlap_cnt), 32'h0);
    cycle(12'h010, 1'b0, 1'b0);
    check("single_grant", 32'(grant), 32'h010);
    check("single_idx", 32'(grant_idx), 32'd4);
    cycle(12'h000, 1'b0, 1'b0);
    check("drop_grant", 32'(grant), 32'h0);

    // Priority without preemption
    cycle(12'h800, 1'b0, 1'b0);
    check("hi_idx11", 32'(grant_idx), 32'd11);
    for (int i = 0; i < 3; i++) begin
      cycle(12'h801, 1'b0, 1'b0);
      check("nopreempt", 32'(grant_idx), 32'd11);
    end
    cycle(12'h001, 1'b0, 1'b0);
    check("handoff_idx0", 32'(grant), 32'h001);
    cycle(12'h000, 1'b0, 1'b0);

    // Hold limit under constant contention
    for (int i = 1; i <= 17; i++) begin
      cycle(12'h003, 1'b0, 1'b0);
      exp_g = (i <= 8) ? 12'h001 : (i <= 16) ? 12'h002 : 12'h001;
      check("hold_alt", 32'(grant), 32'(exp_g));
    end
    for (int i = 0; i < 20; i++) begin
      cycle(12'h001, 1'b0, 1'b0);
      check("hold_alone", 32'(grant), 32'h001);
    end
    cycle(12'h000, 1'b0, 1'b0);

    // Overlap check
    cycle(12'h041, 1'b1, 1'b0);
    check("ovl_idx", 32'(grant_idx), 32'd0);
    check("ovl_pulse", 32'(overlap), 32'd1);
    check("ovl_cnt1", 32'(overlap_cnt), 32'd1);
    cycle(12'h041, 1'b1, 1'b0);
    check("ovl_once", 32'(overlap), 32'd0);
    cycle(12'h000, 1'b0, 1'b0);
    cycle(12'h041, 1'b0, 1'b0);
    check("ovl_disabled", 32'(overlap), 32'd0);
    cycle(12'h000, 1'b0, 1'b0);

    // Overlap counter saturation
    for (int i = 0; i < 300; i++) begin
      cycle(12'h003, 1'b1, 1'b0);
      cycle(12'h000, 1'b1, 1'b0);
    end
    check("ovl_sat", 32'(overlap_cnt), 32'd255);

    // Reset while busy, then a fresh full hold budget
    for (int i = 0; i < 5; i++) cycle(12'h001, 1'b0, 1'b0);
    cycle(12'h001, 1'b0, 1'b1);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_valid", 32'(grant_valid), 32'h0);
    check("midrst_cnt", 32'(overlap_cnt), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      cycle(12'h003, 1'b0, 1'b0);
      exp_g = (i <= 8) ? 12'h001 : 12'h002;
      check("midrst_budget", 32'(grant), 32'(exp_g));
    end

    // Random traffic with sparse requests, sticky holders and occasional reset
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       r = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
        1:       r = NREQ'($urandom);
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) r = '0;
      cycle(r, 1'($urandom), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
